// File: rtl/logic_shiftreg.sv
// logic_shiftreg: universal shift register with hold/shift/rotate/load and a counted burst mode.
// Optional LOGIC_SHIFTREG_PARITY_EN adds a registered XOR-reduce output par.
module logic_shiftreg #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       mode,
  input  logic             rot,
  input  logic             sin,
  input  logic [WIDTH-1:0] din,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic             busy,
  output logic             done
`ifdef LOGIC_SHIFTREG_PARITY_EN
  ,output logic            par
`endif
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic dir, dir_nx, rot_l, rot_l_nx;
  logic [WIDTH-1:0] q_nx;
  logic sout_nx, go, shift, left, wrap, load;
  always_comb begin
    go = start && (mode[0] ^ mode[1]);
    shift = (state == SHIFT) || (state == IDLE && !go && (mode[0] ^ mode[1]));
    load = state == IDLE && !go && mode == 2'b11;
    left = state == SHIFT ? dir : mode[1];
    wrap = state == SHIFT ? rot_l : rot;
    q_nx = shift ? (left ? {q[WIDTH-2:0], wrap ? q[WIDTH-1] : sin}
                         : {wrap ? q[0] : sin, q[WIDTH-1:1]})
         : load ? din : q;
    sout_nx = shift ? (left ? q[WIDTH-1] : q[0]) : sout;
    state_nx = state == IDLE  ? (go ? (len == '0 ? DONE : SHIFT) : IDLE)
             : state == SHIFT ? (cnt == CNT_W'(1) ? DONE : SHIFT)
             : IDLE;
    cnt_nx = (state == IDLE && go) ? len : state == SHIFT ? cnt - 1'b1 : cnt;
    dir_nx = (state == IDLE && go) ? mode[1] : dir;
    rot_l_nx = (state == IDLE && go) ? rot : rot_l;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      dir <= 1'b0;
      rot_l <= 1'b0;
      q <= RST_VAL;
      sout <= 1'b0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      dir <= dir_nx;
      rot_l <= rot_l_nx;
      q <= q_nx;
      sout <= sout_nx;
    end
  end
  assign busy = state == SHIFT;
  assign done = state == DONE;
`ifdef LOGIC_SHIFTREG_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) par <= ^RST_VAL;
    else par <= ^q_nx;
  end
`endif
endmodule

// File: doc/logic_shiftreg.md
Name: logic_shiftreg

Overview:
- Parametrised universal shift register for the digital logic device library; successor to the fixed two-input gate set.
- Hold, shift left/right, rotate and parallel load at any width, plus an autonomous burst mode that shifts a programmed count and then signals done.
- Used as a serialiser/deserialiser building block in mixed-signal test circuits. Single clock domain.

Parameters:
- WIDTH, 8, register width in bits (>=2)
- CNT_W, 4, width of burst length field; max burst = 2^CNT_W-1 shifts
- RST_VAL, 0, register contents after reset (WIDTH bits)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- mode  input  2  00 hold, 01 shift right (toward LSB), 10 shift left (toward MSB), 11 parallel load
- rot  input  1  1: rotate (wrap-around bit replaces sin); 0: shift with sin
- sin  input  1  serial data in
- din  input  WIDTH  parallel load data
- start  input  1  begin burst of len shifts in direction given by mode
- len  input  CNT_W  burst length sampled on start
- q  output  WIDTH  register contents
- sout  output  1  bit shifted out: q[0] for right, q[WIDTH-1] for left; registered
- busy  output  1  burst in progress
- done  output  1  one-cycle pulse after final burst shift

Behaviour:
- Reset (async, rst_n=0): q=RST_VAL, sout=0, busy=0, done=0, FSM=IDLE, counter=0. Reset mid-burst aborts immediately with no done pulse.
- FSM states IDLE, SHIFT, DONE.
- IDLE, start=0: mode applied every cycle. 01: q<={rot?q[0]:sin, q[WIDTH-1:1]}, sout<=q[0]. 10: q<={q[WIDTH-2:0], rot?q[WIDTH-1]:sin}, sout<=q[WIDTH-1]. 11: q<=din, sout unchanged. 00: hold.
- IDLE, start=1 with mode 01 or 10 and len>0: latch direction, rot and len; go to SHIFT; busy=1 from the next cycle. The start cycle performs no shift. The first burst shift occurs on the next edge.
- start with len=0: no shifts. Go directly to DONE, so done pulses one cycle later and busy stays 0.
- start with mode 00 or 11: ignored, and normal IDLE action occurs.
- SHIFT: one shift per cycle using the latched direction and rot. sin is sampled live. The mode, rot and start inputs are ignored. The counter decrements, and when it reaches 1 the final shift occurs and the FSM goes to DONE. Exactly len shifts are performed.
- DONE: busy=0, done=1 for one cycle, no shift, then IDLE. A start asserted during DONE is ignored.
- Latency: parallel load visible on q 1 cycle after the edge. A burst of N occupies cycles 1..N after start, with done at cycle N+1.
- Wrap-around: rotate by WIDTH positions returns the original q. Counter arithmetic is unsigned CNT_W with no underflow below 0.

Optional Feature:
- Macro LOGIC_SHIFTREG_PARITY_EN.
- Defined: extra output port par (1 bit) = registered XOR-reduce of q, updated the same cycle as q. Reset value is the XOR-reduce of RST_VAL.
- Undefined: port absent and no parity logic.

Test Plan:
- Reset, then mode=11 with din=0xA5 -> q=0xA5 after 1 edge; assert rst_n=0 asynchronously mid-cycle -> q=0x00, busy=0 immediately.
- q=0xA5, mode=01, rot=0, sin=1, 3 edges -> q=0xF4, sout=1 (last shifted bit from 0xE9).
- q=0x81, mode=10, rot=1, 8 edges -> q=0x81 (full wrap); after 1 edge q=0x03, sout=1.
- q=0x01, start with mode=10, len=5, rot=0, sin=0 -> busy high for 5 cycles, q=0x20, done pulses exactly one cycle later; mode toggled to 11 mid-burst has no effect.
- start with len=0 -> q unchanged, busy never high, done pulses 1 cycle after start; second start during DONE is ignored.
- Parity build: load 0x07 -> par=1; load 0x0F -> par=0.
